shift_cmd_sequencer: RTL and testbench

//  Upstream controller for the 8-bit universal shift register. It accepts

---
 rtl/shift_cmd_sequencer_if.sv | 28 ++
 rtl/shift_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_sequencer_if.sv
// Command channel into the shift-register sequencer: one op with its data and
// repeat count per valid/ready handshake.
interface shift_cmd_sequencer_if #(
   parameter int W  = 8,
   parameter int CW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [W-1:0]  cmd_data;
   logic [CW-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues LOAD/SHL/SHR/HOLD commands and drives the universal shift register,
// tracking its contents in a shadow copy so idle cycles reload the same value.
module shift_cmd_sequencer #(
   parameter int W     = 8,
   parameter int CW    = 4,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   shift_cmd_sequencer_if.slave cmd,
   output logic                 shift_left,
   output logic                 shift_right,
   output logic [W-1:0]         parallel_in,
   output logic [W-1:0]         shadow,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHL  = 2'b01,
      OP_SHR  = 2'b10,
      OP_HOLD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 + W + CW;
   localparam logic [AW:0]   PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   state_t        state;
   state_t        state_next;

   logic [EW-1:0] fifo_mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;
   op_t           head_op;
   logic [W-1:0]  head_data;
   logic [CW-1:0] head_count;

   op_t           cur_op;
   logic [W-1:0]  cur_data;
   logic [CW-1:0] cnt;

   // Extra pointer bit distinguishes a full FIFO from an empty one.
   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd.cmd_ready = !fifo_full;
   assign push          = cmd.cmd_valid && !fifo_full;
   assign pop           = (state == IDLE) && !fifo_empty;

   assign head       = fifo_mem[rd_ptr[AW-1:0]];
   assign head_op    = op_t'(head[EW-1 -: 2]);
   assign head_data  = head[CW +: W];
   assign head_count = head[CW-1:0];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_data, cmd.cmd_count};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // The shadow follows exactly what the register will do on each edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_op   <= OP_LOAD;
         cur_data <= '0;
         cnt      <= '0;
         shadow   <= '0;
      end else begin
         if (pop) begin
            cur_op   <= head_op;
            cur_data <= head_data;
            cnt      <= head_count;
         end
         if (state == EXEC) begin
            case (cur_op)
               OP_LOAD: shadow <= cur_data;
               OP_SHL: begin
                  shadow <= {shadow[W-2:0], 1'b0};
                  cnt    <= cnt - CNT_ONE;
               end
               OP_SHR: begin
                  shadow <= {1'b0, shadow[W-1:1]};
                  cnt    <= cnt - CNT_ONE;
               end
               default: cnt <= cnt - CNT_ONE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A zero-count action has nothing to execute, so it skips straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               if ((head_op != OP_LOAD) && (head_count == '0)) begin
                  state_next = DONE;
               end else begin
                  state_next = EXEC;
               end
            end
         end
         EXEC: begin
            if ((cur_op == OP_LOAD) || (cnt == CNT_ONE)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      shift_left  = 1'b0;
      shift_right = 1'b0;
      parallel_in = shadow;
      done        = (state == DONE);
      busy        = (state != IDLE) || !fifo_empty;
      if (state == EXEC) begin
         case (cur_op)
            OP_LOAD: parallel_in = cur_data;
            OP_SHL:  shift_left  = 1'b1;
            OP_SHR:  shift_right = 1'b1;
            default: parallel_in = shadow;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Drives directed and random command streams into the sequencer and checks it
// against a value-level model of the commands and of the downstream register.
module tb_shift_cmd_sequencer;

   localparam int W     = 8;
   localparam int CW    = 4;
   localparam int DEPTH = 4;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         shift_left;
   logic         shift_right;
   logic [W-1:0] parallel_in;
   logic [W-1:0] shadow;
   logic         busy;
   logic         done;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_val  = '0;
   int           exp_done = 0;
   int           exp_sl   = 0;
   int           exp_sr   = 0;
   int           hold_cycles = 0;

   logic [W-1:0] reg_model;
   int           done_cnt = 0;
   int           sl_cnt   = 0;
   int           sr_cnt   = 0;
   int           both_cnt = 0;

   shift_cmd_sequencer_if #(.W(W), .CW(CW)) cmd_if ();

   shift_cmd_sequencer #(.W(W), .CW(CW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd_if.slave),
      .shift_left  (shift_left),
      .shift_right (shift_right),
      .parallel_in (parallel_in),
      .shadow      (shadow),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Downstream universal register plus event counters, sampled at each edge.
   always @(posedge clk) begin
      if (reset) begin
         reg_model <= '0;
      end else if (shift_left) begin
         reg_model <= reg_model << 1;
      end else if (shift_right) begin
         reg_model <= reg_model >> 1;
      end else begin
         reg_model <= parallel_in;
      end
      if (!reset) begin
         done_cnt <= done_cnt + int'(done);
         sl_cnt   <= sl_cnt + int'(shift_left);
         sr_cnt   <= sr_cnt + int'(shift_right);
         both_cnt <= both_cnt + int'(shift_left && shift_right);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [W-1:0] expectResult(input logic [1:0] op, input logic [W-1:0] data,
                                                 input int count, input logic [W-1:0] cur);
      logic [W-1:0] r;
      case (op)
         OP_LOAD: r = data;
         OP_SHL:  r = (count >= W) ? '0 : W'(cur << count);
         OP_SHR:  r = (count >= W) ? '0 : W'(cur >> count);
         default: r = cur;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data,
                                input logic [CW-1:0] count, input bit track);
      int waited = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = data;
      cmd_if.cmd_count = count;
      while (cmd_if.cmd_ready !== 1'b1 && waited < 300) begin
         tick();
         waited++;
      end
      hold_cycles = waited;
      if (waited >= 300) begin
         checkOutput("push_timeout", 32'(cmd_if.cmd_ready), 32'd1);
      end else begin
         tick();
      end
      cmd_if.cmd_valid = 1'b0;
      if (track) begin
         exp_val = expectResult(op, data, int'(count), exp_val);
         exp_done++;
         if (op == OP_SHL) exp_sl += int'(count);
         if (op == OP_SHR) exp_sr += int'(count);
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic checkSettled(input string tag);
      checkOutput({tag, "_shadow"}, 32'(shadow), 32'(exp_val));
      checkOutput({tag, "_register"}, 32'(reg_model), 32'(exp_val));
      checkOutput({tag, "_parallel_in"}, 32'(parallel_in), 32'(exp_val));
      checkOutput({tag, "_shifts"}, {30'd0, shift_left, shift_right}, 32'd0);
      checkOutput({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
      checkOutput({tag, "_done_count"}, 32'(done_cnt), 32'(exp_done));
      checkOutput({tag, "_shl_cycles"}, 32'(sl_cnt), 32'(exp_sl));
      checkOutput({tag, "_shr_cycles"}, 32'(sr_cnt), 32'(exp_sr));
      checkOutput({tag, "_both_shifts"}, 32'(both_cnt), 32'd0);
   endtask

   initial begin
      int snap_done;
      int batch;
      logic [1:0]    rop;
      logic [W-1:0]  rdata;
      logic [CW-1:0] rcnt;

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_data  = '0;
      cmd_if.cmd_count = '0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_shadow", 32'(shadow), 32'd0);
      checkOutput("rst_parallel_in", 32'(parallel_in), 32'd0);
      checkOutput("rst_shifts", {30'd0, shift_left, shift_right}, 32'd0);
      checkOutput("rst_done_busy", {30'd0, done, busy}, 32'd0);
      checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
      reset = 1'b0;
      tick();

      // LOAD 0xA5: one load cycle, then a single done pulse
      applyStimulus(OP_LOAD, 8'hA5, 4'd0, 1'b1);
      tick();
      checkOutput("t1_load_pin", 32'(parallel_in), 32'hA5);
      checkOutput("t1_load_shifts", {30'd0, shift_left, shift_right}, 32'd0);
      checkOutput("t1_load_nodone", 32'(done), 32'd0);
      tick();
      checkOutput("t1_done", 32'(done), 32'd1);
      tick();
      checkOutput("t1_done_once", 32'(done), 32'd0);
      checkSettled("t1");

      // LOAD 0x81 then SHL x3: three consecutive shift cycles
      applyStimulus(OP_LOAD, 8'h81, 4'd0, 1'b1);
      waitIdle("t2_load");
      applyStimulus(OP_SHL, 8'h00, 4'd3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("t2_shl_cycle%0d", i), {30'd0, shift_left, shift_right}, 32'd2);
      end
      tick();
      checkOutput("t2_after_shl", {30'd0, shift_left, done}, 32'd1);
      waitIdle("t2");
      checkSettled("t2");

      // LOAD 0xF0 then SHR x0: straight to done, value holds while idle
      applyStimulus(OP_LOAD, 8'hF0, 4'd0, 1'b1);
      waitIdle("t3_load");
      applyStimulus(OP_SHR, 8'h00, 4'd0, 1'b1);
      tick();
      checkOutput("t3_zero_done", {30'd0, done, shift_right}, 32'd2);
      waitIdle("t3");
      tick();
      tick();
      tick();
      checkSettled("t3");

      // Fill the FIFO behind a long HOLD; fifth push must stall
      applyStimulus(OP_HOLD, 8'h00, 4'd15, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         rop   = 2'($urandom_range(0, 3));
         rdata = 8'($urandom);
         rcnt  = 4'($urandom_range(0, 5));
         applyStimulus(rop, rdata, rcnt, 1'b1);
      end
      checkOutput("t4_full_ready", 32'(cmd_if.cmd_ready), 32'd0);
      checkOutput("t4_full_busy", 32'(busy), 32'd1);
      applyStimulus(OP_LOAD, 8'h5A, 4'd0, 1'b1);
      checkOutput("t4_fifth_stalled", 32'(hold_cycles > 0), 32'd1);
      waitIdle("t4");
      checkSettled("t4");

      // LOAD 0xFF, SHR x8 -> 0, then HOLD x5 with no shifts
      applyStimulus(OP_LOAD, 8'hFF, 4'd0, 1'b1);
      applyStimulus(OP_SHR, 8'h00, 4'd8, 1'b1);
      waitIdle("t5_shr");
      checkSettled("t5_shr");
      applyStimulus(OP_HOLD, 8'h00, 4'd5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("t5_hold%0d", i), {23'd0, shift_left, shift_right, reg_model}, 32'd0);
      end
      waitIdle("t5");
      checkSettled("t5");

      // Reset during the second cycle of SHL x6 aborts it without a done pulse
      applyStimulus(OP_LOAD, 8'h3C, 4'd0, 1'b1);
      waitIdle("t6_load");
      snap_done = done_cnt;
      applyStimulus(OP_SHL, 8'h00, 4'd6, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkOutput("t6_shifts", {30'd0, shift_left, shift_right}, 32'd0);
      checkOutput("t6_shadow", 32'(shadow), 32'd0);
      checkOutput("t6_register", 32'(reg_model), 32'd0);
      checkOutput("t6_busy_done", {30'd0, busy, done}, 32'd0);
      checkOutput("t6_ready", 32'(cmd_if.cmd_ready), 32'd1);
      reset = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("t6_no_done", 32'(done_cnt), 32'(snap_done));
      exp_val = '0;
      exp_sl += 1;
      checkSettled("t6");

      // Random command batches against the value-level model
      for (batch = 0; batch < 25; batch++) begin
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            rop   = 2'($urandom_range(0, 3));
            rdata = 8'($urandom);
            rcnt  = 4'($urandom_range(0, 15));
            applyStimulus(rop, rdata, rcnt, 1'b1);
         end
         waitIdle($sformatf("rnd%0d", batch));
         checkSettled($sformatf("rnd%0d", batch));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
